euler_multi_accumulator: RTL and testbench
==========================================

Name: euler_multi_accumulator

Overview:
Multi-channel, signed fixed-point state accumulator for the Euler integration datapath. It holds one state variable x[ch] per ODE channel and applies x[ch] <= x[ch] + in_data on each accepted increment. It adds valid/ready handshaking, load-initial-value, saturating or wrapping arithmetic, per-channel sticky overflow flags and an integration step counter with a programmable stop point. It sits between the h*f(x) product stage and the state readback/writeback logic.

Parameters:
WIDTH, 16, data width of each state register (signed two's complement)
CHANNELS, 4, number of independent state registers (>=1)
CH_W, $clog2(CHANNELS) (min 1), channel index width; derived, do not override
STEP_W, 16, width of step counter
SATURATE, 1, 1 = clamp on signed overflow, 0 = wrap modulo 2^WIDTH

Ports:
clk  in  1  clock, rising edge
rst_async  in  1  asynchronous reset, active-high
rst_sync  in  1  synchronous clear, active-high
clear_flags  in  1  synchronous clear of ovf_sticky
target_steps  in  STEP_W  step count at which done asserts; 0 = run forever
in_valid  in  1  increment/load request valid
in_ready  out  1  block can accept request
in_load  in  1  1 = write in_data into x[in_ch]; 0 = accumulate
in_ch  in  CH_W  target channel
in_data  in  WIDTH  signed increment or initial value
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
out_ch  out  CH_W  channel of result
out_data  out  WIDTH  updated x[out_ch]
out_ovf  out  1  overflow occurred on this result
out_carry  out  1  unsigned carry-out of this result's add
ovf_sticky  out  CHANNELS  per-channel sticky overflow
step_count  out  STEP_W  completed sweeps
done  out  1  step_count == target_steps and target_steps != 0

Behaviour:
- Priority: rst_async > rst_sync > clear_flags/transfer. rst_async and rst_sync clear all x[], out_valid, out_ch, out_data, out_ovf, out_carry, ovf_sticky and step_count to 0. After either reset, done=0 and in_ready=1.
- Transfer occurs when in_valid && in_ready. in_ready = !done && (!out_valid || out_ready). Output is a single registered stage: no skid buffer and no combinational path from in_* to out_*.
- Latency is 1 cycle. On a transfer at edge N, x[in_ch] and the out_* registers update at edge N. Sustained throughput is 1/cycle when out_ready=1. Back-to-back increments to the same channel use the already-updated x with no hazard.
- Accumulate (in_load=0):
  - sum = x + in_data at WIDTH+1 bits.
  - carry = unsigned bit WIDTH.
  - ovf = operand signs equal and result sign differs.
  - If ovf and SATURATE=1, the result is 0x7FFF..F for positive operands and 0x800..0 for negative operands. Otherwise the result is the low WIDTH bits.
  - The result is written to x[in_ch] and out_data.
- Load (in_load=1): x[in_ch] <= in_data. out_data = in_data, out_ovf = 0, out_carry = 0. Load does not count as a step.
- ovf_sticky[ch] is set on any accumulate with ovf=1. clear_flags clears all bits. If a set and clear_flags occur in the same cycle, the set wins for that channel.
- step_count increments, wrapping at 2^STEP_W, on each accumulate transfer with in_ch == CHANNELS-1.
- done is combinational from step_count and target_steps. When done=1, in_ready=0 and any pending out_valid still drains. Changing target_steps re-evaluates done immediately.
- out_valid && !out_ready holds all out_* values stable.
- in_ch >= CHANNELS (non-power-of-2 CHANNELS): the request is accepted, has no state change and no step count, and produces out_valid with out_data=0 and out_ovf=0.
- rst_sync asserted mid-stream drops the in-flight result: out_valid=0 next cycle.

Decomposition:
- Shared package euler_pkg holds:
  - saturation constants MAX_POS(WIDTH) and MAX_NEG(WIDTH) as functions;
  - a result struct {data, ovf, carry};
  - function sat_add(a, b, saturate) returning that struct.
- One natural sub-module: euler_sat_adder (combinational, WIDTH parameter, SATURATE parameter), instantiated once. The channel register file, handshake stage and step counter stay in the top module.

Test Plan:
- Reset/load: rst_async pulse, load ch0=0x0100, ch1=0xFF00 -> out_data 0x0100 then 0xFF00, out_ovf=0, step_count=0.
- Accumulate: ch2 x=0x7FF0 +0x0020, SATURATE=1 -> out_data=0x7FFF, out_ovf=1, ovf_sticky[2]=1. Same with SATURATE=0 -> out_data=0x8010. Then x=0xFFFF +0x0001 -> out_data=0, out_carry=1, out_ovf=0.
- Backpressure: out_ready=0 for 3 cycles with in_valid held -> in_ready=0, out_* stable, no x change. Release -> one result per cycle, values match model.
- Steps/done: CHANNELS=4, target_steps=3, sweep ch0..3 with +1 -> step_count 1,2,3. done=1 after third ch3 transfer, in_ready=0. rst_sync -> step_count=0, done=0.
- Flags: an ovf on ch1 coincident with clear_flags -> ovf_sticky[1]=1. clear_flags alone next cycle -> 0.
- Reset mid-stream: rst_sync while out_valid=1 with out_ready=0 -> out_valid=0 and all x=0 next cycle. Async reset mid-cycle clears immediately without a clock edge.

Source files
------------

// File: rtl/euler_pkg.sv
// Shared arithmetic helpers for the Euler accumulator: saturation limits and a
// width-generic signed add that reports overflow and unsigned carry.
package euler_pkg;

    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] word_t;

    typedef struct packed {
        word_t data;
        logic  ovf;
        logic  carry;
    } sat_res_t;

    function automatic word_t width_mask(input int w);
        return (w >= MAX_W) ? '1 : ((word_t'(1) << w) - word_t'(1));
    endfunction

    function automatic word_t MAX_POS(input int w);
        return width_mask(w) >> 1;
    endfunction

    function automatic word_t MAX_NEG(input int w);
        return width_mask(w) & ~(width_mask(w) >> 1);
    endfunction

    // Only the low w bits of a and b are significant; the result is masked to w bits.
    function automatic sat_res_t sat_add(input word_t a, input word_t b,
                                         input logic saturate, input int w);
        sat_res_t         res;
        word_t            m;
        word_t            sbit;
        logic [MAX_W:0]   full;
        logic             sa;
        logic             sb;
        logic             sr;
        m         = width_mask(w);
        sbit      = word_t'(1) << (w - 1);
        full      = {1'b0, a & m} + {1'b0, b & m};
        res.carry = |(full & ({{MAX_W{1'b0}}, 1'b1} << w));
        res.data  = full[MAX_W-1:0] & m;
        sa        = |(a & sbit);
        sb        = |(b & sbit);
        sr        = |(res.data & sbit);
        res.ovf   = (sa == sb) && (sr != sa);
        if (res.ovf && saturate) begin
            res.data = sa ? MAX_NEG(w) : MAX_POS(w);
        end
        return res;
    endfunction

endpackage

// File: rtl/euler_multi_accumulator_if.sv
// Increment request and result handshake bundle for euler_multi_accumulator.
interface euler_multi_accumulator_if #(
    parameter int WIDTH = 16,
    parameter int CH_W  = 2
);
    logic             in_valid;
    logic             in_ready;
    logic             in_load;
    logic [CH_W-1:0]  in_ch;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [CH_W-1:0]  out_ch;
    logic [WIDTH-1:0] out_data;
    logic             out_ovf;
    logic             out_carry;

    modport master (
        output in_valid, in_load, in_ch, in_data, out_ready,
        input  in_ready, out_valid, out_ch, out_data, out_ovf, out_carry
    );

    modport slave (
        input  in_valid, in_load, in_ch, in_data, out_ready,
        output in_ready, out_valid, out_ch, out_data, out_ovf, out_carry
    );
endinterface

// File: rtl/euler_sat_adder.sv
// Signed WIDTH-bit adder with optional clamp on overflow, plus overflow/carry flags.
// Latency: combinational.
// Backpressure: none; pure datapath.
module euler_sat_adder
    import euler_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int SATURATE = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             ovf,
    output logic             carry
);
    sat_res_t res;

    assign res   = sat_add(word_t'(a), word_t'(b), SATURATE != 0, WIDTH);
    assign sum   = res.data[WIDTH-1:0];
    assign ovf   = res.ovf;
    assign carry = res.carry;

    // Upper container bits are always zero after masking.
    if (WIDTH < MAX_W) begin : g_hi
        logic unused_hi;
        assign unused_hi = ^res.data[MAX_W-1:WIDTH];
    end
endmodule

// File: rtl/euler_multi_accumulator.sv
// Multi-channel Euler state accumulator: x[ch] <= x[ch] + in_data, or load, with step counting.
// Latency: 1 cycle from accepted request to registered result.
// Backpressure: single output register; in_ready drops while a result stalls or done is high.
module euler_multi_accumulator
    import euler_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    parameter  int STEP_W   = 16,
    parameter  int SATURATE = 1,
    localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                   clk,
    input  logic                   rst_async,
    input  logic                   rst_sync,
    input  logic                   clear_flags,
    input  logic [STEP_W-1:0]      target_steps,
    euler_multi_accumulator_if.slave bus,
    output logic [CHANNELS-1:0]    ovf_sticky,
    output logic [STEP_W-1:0]      step_count,
    output logic                   done
);
    logic [WIDTH-1:0] x_q [CHANNELS];
    logic [WIDTH-1:0] cur_x;
    logic [WIDTH-1:0] add_sum;
    logic             add_ovf;
    logic             add_carry;
    logic [WIDTH-1:0] res_data;
    logic             res_ovf;
    logic             res_carry;
    logic             ch_ok;
    logic             last_ch;
    logic             xfer;

    assign done         = (target_steps != '0) && (step_count == target_steps);
    assign bus.in_ready = !done && (!bus.out_valid || bus.out_ready);
    assign xfer         = bus.in_valid && bus.in_ready;
    assign ch_ok        = 32'(bus.in_ch) < CHANNELS;
    assign last_ch      = 32'(bus.in_ch) == CHANNELS - 1;

    // Out-of-range channels read as zero so the adder never sees an X.
    always_comb begin
        cur_x = '0;
        if (ch_ok) begin
            cur_x = x_q[bus.in_ch];
        end
    end

    euler_sat_adder #(
        .WIDTH    (WIDTH),
        .SATURATE (SATURATE)
    ) u_adder (
        .a     (cur_x),
        .b     (bus.in_data),
        .sum   (add_sum),
        .ovf   (add_ovf),
        .carry (add_carry)
    );

    always_comb begin
        res_data  = '0;
        res_ovf   = 1'b0;
        res_carry = 1'b0;
        if (ch_ok) begin
            if (bus.in_load) begin
                res_data = bus.in_data;
            end else begin
                res_data  = add_sum;
                res_ovf   = add_ovf;
                res_carry = add_carry;
            end
        end
    end

    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            for (int i = 0; i < CHANNELS; i++) x_q[i] <= '0;
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_data  <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_carry <= 1'b0;
            ovf_sticky    <= '0;
            step_count    <= '0;
        end else if (rst_sync) begin
            for (int i = 0; i < CHANNELS; i++) x_q[i] <= '0;
            bus.out_valid <= 1'b0;
            bus.out_ch    <= '0;
            bus.out_data  <= '0;
            bus.out_ovf   <= 1'b0;
            bus.out_carry <= 1'b0;
            ovf_sticky    <= '0;
            step_count    <= '0;
        end else begin
            if (clear_flags) begin
                ovf_sticky <= '0;
            end
            if (bus.out_valid && bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
            if (xfer) begin
                bus.out_valid <= 1'b1;
                bus.out_ch    <= bus.in_ch;
                bus.out_data  <= res_data;
                bus.out_ovf   <= res_ovf;
                bus.out_carry <= res_carry;
                if (ch_ok) begin
                    x_q[bus.in_ch] <= res_data;
                    // Later assignment lets a fresh overflow beat a same-cycle clear.
                    if (!bus.in_load && add_ovf) begin
                        ovf_sticky[bus.in_ch] <= 1'b1;
                    end
                    if (!bus.in_load && last_ch) begin
                        step_count <= step_count + STEP_W'(1);
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_euler_multi_accumulator.sv
// Directed bench: saturating and wrapping instances share stimulus; checks use immediate assertions.
module tb_euler_multi_accumulator;
    logic        clk = 1'b0;
    logic        rst_async;
    logic        rst_sync;
    logic        clear_flags;
    logic [15:0] target_steps;
    logic [3:0]  sticky_a, sticky_b;
    logic [15:0] step_a, step_b;
    logic        done_a, done_b;
    int          checks = 0;
    int          errors = 0;

    euler_multi_accumulator_if #(.WIDTH(16), .CH_W(2)) ifa ();
    euler_multi_accumulator_if #(.WIDTH(16), .CH_W(2)) ifb ();

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.in_load   = ifa.in_load;
    assign ifb.in_ch     = ifa.in_ch;
    assign ifb.in_data   = ifa.in_data;
    assign ifb.out_ready = ifa.out_ready;

    euler_multi_accumulator #(.WIDTH(16), .CHANNELS(4), .STEP_W(16), .SATURATE(1)) dut_sat (
        .clk(clk), .rst_async(rst_async), .rst_sync(rst_sync), .clear_flags(clear_flags),
        .target_steps(target_steps), .bus(ifa.slave), .ovf_sticky(sticky_a),
        .step_count(step_a), .done(done_a)
    );

    euler_multi_accumulator #(.WIDTH(16), .CHANNELS(4), .STEP_W(16), .SATURATE(0)) dut_wrap (
        .clk(clk), .rst_async(rst_async), .rst_sync(rst_sync), .clear_flags(clear_flags),
        .target_steps(target_steps), .bus(ifb.slave), .ovf_sticky(sticky_b),
        .step_count(step_b), .done(done_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One-cycle request; assumes in_ready is high when called.
    task automatic send(input logic load, input logic [1:0] ch, input logic [15:0] data);
        ifa.in_valid = 1'b1;
        ifa.in_load  = load;
        ifa.in_ch    = ch;
        ifa.in_data  = data;
        tick();
        ifa.in_valid = 1'b0;
    endtask

    initial begin
        rst_async     = 1'b1;
        rst_sync      = 1'b0;
        clear_flags   = 1'b0;
        target_steps  = 16'd0;
        ifa.in_valid  = 1'b0;
        ifa.in_load   = 1'b0;
        ifa.in_ch     = 2'd0;
        ifa.in_data   = 16'h0;
        ifa.out_ready = 1'b1;
        #3;
        chk("rst_out_valid", 32'(ifa.out_valid), 32'd0);
        chk("rst_in_ready",  32'(ifa.in_ready),  32'd1);
        chk("rst_step",      32'(step_a),        32'd0);
        chk("rst_sticky",    32'(sticky_a),      32'd0);
        chk("rst_done",      32'(done_a),        32'd0);
        #9;
        rst_async = 1'b0;
        tick();

        // Loads
        send(1'b1, 2'd0, 16'h0100);
        chk("load0_valid", 32'(ifa.out_valid), 32'd1);
        chk("load0_data",  32'(ifa.out_data),  32'h0100);
        chk("load0_ch",    32'(ifa.out_ch),    32'd0);
        send(1'b1, 2'd1, 16'hFF00);
        chk("load1_data",  32'(ifa.out_data),  32'hFF00);
        chk("load1_ovf",   32'(ifa.out_ovf),   32'd0);
        chk("load1_step",  32'(step_a),        32'd0);

        // Positive overflow on ch2: clamp vs wrap
        send(1'b1, 2'd2, 16'h7FF0);
        send(1'b0, 2'd2, 16'h0020);
        chk("sat_data",    32'(ifa.out_data),  32'h7FFF);
        chk("sat_ovf",     32'(ifa.out_ovf),   32'd1);
        chk("sat_carry",   32'(ifa.out_carry), 32'd0);
        chk("sat_sticky",  32'(sticky_a),      32'h4);
        chk("wrap_data",   32'(ifb.out_data),  32'h8010);
        chk("wrap_ovf",    32'(ifb.out_ovf),   32'd1);

        // -1 + 1: carry out, no signed overflow
        send(1'b1, 2'd1, 16'hFFFF);
        send(1'b0, 2'd1, 16'h0001);
        chk("carry_data",  32'(ifa.out_data),  32'h0000);
        chk("carry_c",     32'(ifa.out_carry), 32'd1);
        chk("carry_ovf",   32'(ifa.out_ovf),   32'd0);

        // Backpressure with request held on ch0 (x=0x0100)
        tick();
        chk("bp_idle_valid", 32'(ifa.out_valid), 32'd0);
        ifa.out_ready = 1'b0;
        ifa.in_valid  = 1'b1;
        ifa.in_load   = 1'b0;
        ifa.in_ch     = 2'd0;
        ifa.in_data   = 16'h0010;
        #1;
        chk("bp_ready_pre", 32'(ifa.in_ready), 32'd1);
        tick();
        chk("bp_first_data", 32'(ifa.out_data), 32'h0110);
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(ifa.in_ready),  32'd0);
            chk("bp_valid",    32'(ifa.out_valid), 32'd1);
            tick();
            chk("bp_hold_data", 32'(ifa.out_data), 32'h0110);
        end
        ifa.out_ready = 1'b1;
        tick();
        chk("bp_rel1_data", 32'(ifa.out_data), 32'h0120);
        tick();
        chk("bp_rel2_data", 32'(ifa.out_data), 32'h0130);
        chk("bp_rel2_valid", 32'(ifa.out_valid), 32'd1);
        ifa.in_valid = 1'b0;

        // Step counting and done
        rst_sync = 1'b1;
        tick();
        rst_sync = 1'b0;
        chk("rs_step",  32'(step_a),        32'd0);
        chk("rs_valid", 32'(ifa.out_valid), 32'd0);
        target_steps = 16'd3;
        ifa.in_valid = 1'b1;
        ifa.in_load  = 1'b0;
        ifa.in_data  = 16'h0001;
        for (int s = 0; s < 3; s++) begin
            for (int c = 0; c < 4; c++) begin
                ifa.in_ch = 2'(c);
                tick();
                chk("sweep_data", 32'(ifa.out_data), 32'(s + 1));
                if (c == 3) chk("sweep_step", 32'(step_a), 32'(s + 1));
            end
        end
        ifa.in_valid = 1'b0;
        chk("done_set",      32'(done_a),       32'd1);
        chk("done_in_ready", 32'(ifa.in_ready), 32'd0);
        tick();
        chk("done_drained",  32'(ifa.out_valid), 32'd0);
        chk("done_held",     32'(done_a),        32'd1);
        target_steps = 16'd4;
        #1;
        chk("tgt_done",      32'(done_a),       32'd0);
        chk("tgt_in_ready",  32'(ifa.in_ready), 32'd1);
        target_steps = 16'd3;
        #1;
        chk("tgt_back_done", 32'(done_a),       32'd1);
        rst_sync = 1'b1;
        tick();
        rst_sync = 1'b0;
        chk("rs2_step",  32'(step_a),       32'd0);
        chk("rs2_done",  32'(done_a),       32'd0);
        chk("rs2_ready", 32'(ifa.in_ready), 32'd1);

        // Sticky set beats coincident clear
        send(1'b1, 2'd2, 16'h7FFF);
        send(1'b0, 2'd2, 16'h0001);
        chk("flag_pre", 32'(sticky_a), 32'h4);
        send(1'b1, 2'd1, 16'h7FFF);
        clear_flags = 1'b1;
        send(1'b0, 2'd1, 16'h0001);
        chk("flag_coincident", 32'(sticky_a), 32'h2);
        tick();
        clear_flags = 1'b0;
        chk("flag_cleared", 32'(sticky_a), 32'h0);

        // Synchronous reset drops a stalled result
        ifa.out_ready = 1'b0;
        send(1'b1, 2'd0, 16'h1234);
        chk("mid_valid", 32'(ifa.out_valid), 32'd1);
        rst_sync = 1'b1;
        tick();
        rst_sync = 1'b0;
        ifa.out_ready = 1'b1;
        chk("mid_rs_valid", 32'(ifa.out_valid), 32'd0);
        chk("mid_rs_data",  32'(ifa.out_data),  32'h0);
        send(1'b0, 2'd0, 16'h0005);
        chk("mid_x0_zero", 32'(ifa.out_data), 32'h0005);
        send(1'b0, 2'd1, 16'h0005);
        chk("mid_x1_zero", 32'(ifa.out_data), 32'h0005);

        // Asynchronous reset between edges
        send(1'b1, 2'd2, 16'h0042);
        chk("ar_pre_data", 32'(ifa.out_data), 32'h0042);
        #3;
        rst_async = 1'b1;
        #1;
        chk("ar_valid", 32'(ifa.out_valid), 32'd0);
        chk("ar_data",  32'(ifa.out_data),  32'h0);
        chk("ar_step",  32'(step_a),        32'd0);
        #2;
        rst_async = 1'b0;
        tick();
        send(1'b0, 2'd2, 16'h0001);
        chk("ar_x2_zero", 32'(ifa.out_data), 32'h0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
